mux_sel_pipe: RTL

Parametrised N-way data selector with a registered output stage and valid/ready handshakes on every input channel and on the output. Generalises the 32-bit 2:1 combinational mux used in the datapath. Adds channel count, width, per-channel backpressure, and a runtime choice between explicit-select and round-robin arbitration. Used where several producers feed one consumer, e.g. writeback-source merging and multi-requester memory ports.

---
 rtl/mux_pkg.sv | 28 ++
 rtl/mux_sel_pipe_rr_pick.sv | 31 +++
 rtl/mux_sel_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and the rotating-priority search used by the N-way selector
// and its reference model.
package mux_pkg;

  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t;

  localparam int MAX_N    = 16;
  localparam int MAX_PTRW = 4;

  // Index of the first set bit of vec[n-1:0] scanning ptr, ptr+1, ... mod n;
  // -1 when nothing is set. The scan runs backwards so the lowest offset wins.
  function automatic int first_from(input logic [MAX_PTRW-1:0] ptr,
                                    input logic [MAX_N-1:0]    vec,
                                    input int                  n);
    int j;
    int r;
    r = -1;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (j < MAX_N && vec[j[3:0]]) r = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_pipe_rr_pick.sv
// Combinational rotating-priority search: first asserted bit of vec
// starting at ptr and wrapping at N.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    vec,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [MAX_PTRW-1:0] w_ptr;
  logic [MAX_N-1:0]    w_vec;
  int                  w_res;

  assign w_ptr = MAX_PTRW'(ptr);
  assign w_vec = MAX_N'(vec);

  always_comb begin
    w_res = first_from(w_ptr, w_vec, N);
    found = (w_res >= 0);
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_res == i) idx = SELW'(i);
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-way valid/ready data selector with a single registered output stage and
// a runtime choice between explicit-select and round-robin arbitration.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode_rr,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  localparam int NP = 1 << SELW;

  // Handshake: a word moves on a channel when valid and ready are both high
  // at a rising edge; ready never depends on the same channel's valid alone.
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SELW-1:0]   r_out_chan;
  logic [SELW-1:0]   r_rr_ptr;
  logic              r_sel_err;

  mux_mode_t         w_mode;
  logic              w_can_accept;
  logic              w_sel_in_range;
  logic [NP-1:0]     w_valid_ext;
  logic              w_rr_found;
  logic [SELW-1:0]   w_rr_idx;
  logic              w_grant_found;
  logic [SELW-1:0]   w_grant_idx;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_grant_data;
  logic [SELW-1:0]   w_ptr_next;

  assign w_mode         = mux_mode_t'(mode_rr);
  assign w_can_accept   = !r_out_valid || out_ready;
  assign w_sel_in_range = ({1'b0, sel} < (SELW + 1)'(N));
  assign w_valid_ext    = NP'(in_valid);

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .vec   (in_valid),
    .ptr   (r_rr_ptr),
    .found (w_rr_found),
    .idx   (w_rr_idx)
  );

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    if (w_mode == MODE_RR) begin
      w_grant_found = w_rr_found;
      w_grant_idx   = w_rr_idx;
    end else if (w_sel_in_range && w_valid_ext[sel]) begin
      w_grant_found = 1'b1;
      w_grant_idx   = sel;
    end
  end

  // Ready is masked by reset so nothing is consumed while the stage is cleared.
  assign w_xfer   = w_grant_found && w_can_accept && !rst;
  assign in_ready = w_xfer ? (N'(1) << w_grant_idx) : '0;

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SELW'(i)) w_grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_next = (w_grant_idx == SELW'(N - 1)) ? '0 : w_grant_idx + SELW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= '0;
      r_sel_err   <= 1'b0;
    end else begin
      r_sel_err <= (w_mode == MODE_SEL) && !w_sel_in_range;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_chan  <= w_grant_idx;
        if (w_mode == MODE_RR) r_rr_ptr <= w_ptr_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign sel_err   = r_sel_err;

endmodule
